// File: rtl/l2_cache_assoc.sv
// ---------------------------------------------------------------------------
// l2_cache_assoc
//   N-way set-associative write-back L2 cache with tree-PLRU replacement,
//   per-byte write enables and an integrated request/miss FSM. Sits between
//   the L1 caches and the cacheline adaptor; 256-bit lines on both sides.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   mem_*                CPU-side request (read/write held until mem_resp),
//                        256-bit data, 32-bit byte enable, one-cycle mem_resp
//   pmem_*               adaptor side: line fill (pmem_read), writeback
//                        (pmem_write), line-aligned address, 256-bit data,
//                        pmem_resp completion pulse
//   perf_hits/misses/writebacks
//                        event counters, present only when the macro
//                        L2_PERF_CNT_EN is defined; tied to 0 otherwise
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for mem_read or mem_write
// CHECK  | tag compare; hit -> RESPOND, miss -> pick victim
// RESPOND| mem_resp pulse for one cycle
// WRITEBACK | dirty victim line being written to the adaptor
// FILL   | requested line being fetched into the victim way
// ---------------------------------------------------------------------------
module l2_cache_assoc #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int WAYS     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata256,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata256,
    input  logic [255:0] pmem_rdata256,
    input  logic         pmem_resp,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses,
    output logic [31:0]  perf_writebacks
);

    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int LOG_W    = $clog2(WAYS);
    localparam int PLRU_W   = WAYS - 1;

    typedef enum logic [2:0] {IDLE, CHECK, RESPOND, WRITEBACK, FILL} state_t;

    state_t state, state_n;

    logic [255:0]       data_arr  [NUM_SETS][WAYS];
    logic [S_TAG-1:0]   tag_arr   [NUM_SETS][WAYS];
    logic [WAYS-1:0]    valid_arr [NUM_SETS];
    logic [WAYS-1:0]    dirty_arr [NUM_SETS];
    logic [PLRU_W-1:0]  plru_arr  [NUM_SETS];

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_set;
    logic               hit, any_inv, victim_dirty;
    logic [LOG_W-1:0]   hit_way, inv_way, plru_way, victim_way;
    logic [LOG_W-1:0]   victim_q, way_q;
    logic               unused_addr_bits;

    assign req_tag = mem_address[31:S_OFFSET+S_INDEX];
    assign req_set = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign unused_addr_bits = ^mem_address[S_OFFSET-1:0];

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    // A node bit of 1 means the victim lies in the right subtree.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] v,
                                                     input logic [LOG_W-1:0]  way);
        logic [PLRU_W-1:0] r;
        logic [PLRU_W-1:0] mask;
        logic              d;
        int                node;
        r    = v;
        node = 0;
        for (int l = 0; l < LOG_W; l++) begin
            d    = way[LOG_W-1-l];
            mask = PLRU_W'(1) << node;
            r    = d ? (r & ~mask) : (r | mask);
            node = 2 * node + 1 + int'(d);
        end
        return r;
    endfunction

    function automatic logic [255:0] merge_bytes(input logic [255:0] old_line,
                                                 input logic [255:0] wdata,
                                                 input logic [31:0]  be);
        logic [255:0] r;
        r = old_line;
        for (int i = 0; i < 32; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    // Lowest-index hit and lowest-index invalid way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_arr[req_set][w] && (tag_arr[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = LOG_W'(w);
            end
            if (!valid_arr[req_set][w]) begin
                any_inv = 1'b1;
                inv_way = LOG_W'(w);
            end
        end
    end

    always_comb begin
        logic [PLRU_W-1:0] sh;
        int                node;
        node = 0;
        sh   = '0;
        for (int l = 0; l < LOG_W; l++) begin
            sh   = plru_arr[req_set] >> node;
            node = 2 * node + 1 + int'(sh[0]);
        end
        plru_way = LOG_W'(node - (WAYS - 1));
    end

    assign victim_way   = any_inv ? inv_way : plru_way;
    assign victim_dirty = valid_arr[req_set][victim_way] & dirty_arr[req_set][victim_way];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = '0;
        pmem_wdata256 = data_arr[req_set][victim_q];
        mem_rdata256  = data_arr[req_set][way_q];
        case (state)
            IDLE: begin
                if (mem_read || mem_write) state_n = CHECK;
            end
            CHECK: begin
                if (hit)               state_n = RESPOND;
                else if (victim_dirty) state_n = WRITEBACK;
                else                   state_n = FILL;
            end
            RESPOND: begin
                mem_resp = 1'b1;
                state_n  = IDLE;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[req_set][victim_q], req_set, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_n = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_set, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_n = CHECK;
            end
            default: state_n = IDLE;
        endcase
    end

    // Valid/dirty/PLRU state: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            if (state == CHECK && hit) begin
                plru_arr[req_set] <= plru_touch(plru_arr[req_set], hit_way);
                if (mem_write) dirty_arr[req_set][hit_way] <= 1'b1;
            end
            if (state == FILL && pmem_resp) begin
                valid_arr[req_set][victim_q] <= 1'b1;
                dirty_arr[req_set][victim_q] <= 1'b0;
                plru_arr[req_set]            <= plru_touch(plru_arr[req_set], victim_q);
            end
        end
    end

    // Line data, tags and way pointers are not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CHECK) begin
                if (hit) begin
                    way_q <= hit_way;
                    if (mem_write)
                        data_arr[req_set][hit_way] <= merge_bytes(data_arr[req_set][hit_way],
                                                                  mem_wdata256, mem_byte_enable256);
                end else begin
                    victim_q <= victim_way;
                end
            end
            if (state == FILL && pmem_resp) begin
                data_arr[req_set][victim_q] <= pmem_rdata256;
                tag_arr[req_set][victim_q]  <= req_tag;
            end
        end
    end

`ifdef L2_PERF_CNT_EN
    logic [31:0] hits_q, misses_q, wbs_q;
    logic        refill_q;   // the next CHECK is the one following a fill

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
            refill_q <= 1'b0;
        end else begin
            if (state == CHECK) begin
                refill_q <= 1'b0;
                if (hit && !refill_q) hits_q   <= hits_q + 32'd1;
                if (!hit)             misses_q <= misses_q + 32'd1;
            end
            if (state == FILL && pmem_resp)      refill_q <= 1'b1;
            if (state == WRITEBACK && pmem_resp) wbs_q    <= wbs_q + 32'd1;
        end
    end

    assign perf_hits       = hits_q;
    assign perf_misses     = misses_q;
    assign perf_writebacks = wbs_q;
`else
    assign perf_hits       = '0;
    assign perf_misses     = '0;
    assign perf_writebacks = '0;
`endif

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Self-checking bench for l2_cache_assoc at default parameters
// (8 ways, 8 sets, 32-byte lines). A line-level cache model plus a
// backing-memory model predict hits, victims, writebacks and read data.
module tb_l2_cache_assoc;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata256;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata256;
    logic [255:0] pmem_rdata256;
    logic         pmem_resp;
    logic [31:0]  perf_hits, perf_misses, perf_writebacks;

    l2_cache_assoc dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata256(pmem_wdata256), .pmem_rdata256(pmem_rdata256), .pmem_resp(pmem_resp),
        .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_writebacks(perf_writebacks)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    bit           m_valid [8][8];
    bit           m_dirty [8][8];
    logic [23:0]  m_tag   [8][8];
    logic [255:0] m_data  [8][8];
    bit           m_plru  [8][7];
    logic [255:0] mem [logic [31:0]];
    int           m_hits, m_misses, m_wbs;

    // results of the last do_req
    logic [255:0] last_rd;
    bit           last_hit, last_wb;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_data;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] r;
        if (mem.exists(a)) return mem[a];
        for (int k = 0; k < 8; k++) r[32*k +: 32] = a ^ (32'h0101_0101 * k) ^ 32'hC0DE_0000;
        return r;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 8; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
            for (int n = 0; n < 7; n++) m_plru[s][n] = 0;
        end
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endfunction

    // level l node covering way w sits at (2^l - 1) + (w >> (3-l));
    // it must point to the half that does not contain w.
    function automatic void model_touch(input int s, input int w);
        for (int l = 0; l < 3; l++) begin
            int node = (1 << l) - 1 + (w >> (3 - l));
            int dir  = (w >> (2 - l)) & 1;
            m_plru[s][node] = (dir == 0);
        end
    endfunction

    function automatic int model_plru_victim(input int s);
        int w = 0;
        for (int l = 0; l < 3; l++) w = 2 * w + int'(m_plru[s][(1 << l) - 1 + w]);
        return w;
    endfunction

    task automatic model_access(input logic [31:0] addr, input bit wr,
                                input logic [255:0] wd, input logic [31:0] be,
                                output bit e_hit, output bit e_wb,
                                output logic [31:0] wb_addr, output logic [255:0] wb_data,
                                output logic [255:0] e_rd);
        int          s  = int'(addr[7:5]);
        logic [23:0] t  = addr[31:8];
        int          hw = -1;
        int          v  = -1;
        for (int w = 7; w >= 0; w--) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        e_hit = (hw >= 0);
        e_wb = 0; wb_addr = '0; wb_data = '0;
        if (!e_hit) begin
            m_misses++;
            for (int w = 7; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = model_plru_victim(s);
            if (m_valid[s][v] && m_dirty[s][v]) begin
                e_wb    = 1;
                wb_addr = {m_tag[s][v], addr[7:5], 5'b0};
                wb_data = m_data[s][v];
                mem[wb_addr] = wb_data;
                m_wbs++;
            end
            m_data[s][v]  = mem_line({addr[31:5], 5'b0});
            m_tag[s][v]   = t;
            m_valid[s][v] = 1;
            m_dirty[s][v] = 0;
            hw = v;
        end else begin
            m_hits++;
        end
        model_touch(s, hw);
        if (wr) begin
            for (int b = 0; b < 32; b++) if (be[b]) m_data[s][hw][8*b +: 8] = wd[8*b +: 8];
            m_dirty[s][hw] = 1;
        end
        e_rd = m_data[s][hw];
    endtask

    // ---------------- one request, checked every cycle ----------------
    task automatic do_req(input logic [31:0] addr, input bit wr,
                          input logic [255:0] wd, input logic [31:0] be);
        bit           e_hit, e_wb, wb_seen, rd_seen, done;
        logic [31:0]  wb_addr;
        logic [255:0] wb_data, e_rd, fill;
        int           cyc;
        fill = mem_line({addr[31:5], 5'b0});
        model_access(addr, wr, wd, be, e_hit, e_wb, wb_addr, wb_data, e_rd);
        wb_seen = 0; rd_seen = 0; done = 0; cyc = 0;
        last_wb = 0; last_wb_addr = '0; last_wb_data = '0;
        mem_address        = addr;
        mem_write          = wr;
        mem_read           = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
        mem_wdata256       = wd;
        mem_byte_enable256 = be;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            pmem_resp = 1'b0;
            if (mem_resp) begin
                if (e_hit) check("hit_latency", cyc, 2);
                check("miss_filled", rd_seen, !e_hit);
                check("wb_done", wb_seen, e_wb);
                if (!wr) check("rdata", mem_rdata256, e_rd);
                last_rd  = mem_rdata256;
                last_hit = !rd_seen;
                done     = 1;
            end else if (pmem_write) begin
                check("wb_expected", e_wb, 1'b1);
                check("wb_addr", pmem_address, wb_addr);
                check("wb_data", pmem_wdata256, wb_data);
                check("wb_before_fill", rd_seen, 1'b0);
                wb_seen = 1;
                last_wb = 1; last_wb_addr = pmem_address; last_wb_data = pmem_wdata256;
                pmem_rdata256 = {8{$urandom}};
                pmem_resp = ($urandom_range(0, 1) == 1);
            end else if (pmem_read) begin
                check("fill_expected", e_hit, 1'b0);
                check("fill_addr", pmem_address, {addr[31:5], 5'b0});
                check("fill_order", wb_seen, e_wb);
                rd_seen = 1;
                pmem_rdata256 = fill;
                pmem_resp = ($urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 7) == 0) begin
                pmem_rdata256 = {8{$urandom}};
                pmem_resp = 1'b1;      // spurious; must be ignored
            end
        end
        if (!done) check("req_timeout", 0, 1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_perf(input string tag, input int eh, input int em, input int ew);
`ifdef L2_PERF_CNT_EN
        check({tag, "_hits"}, perf_hits, eh);
        check({tag, "_misses"}, perf_misses, em);
        check({tag, "_wbs"}, perf_writebacks, ew);
`else
        check({tag, "_hits"}, perf_hits, 0);
        check({tag, "_misses"}, perf_misses, 0);
        check({tag, "_wbs"}, perf_writebacks, 0);
        if (eh < 0 || em < 0 || ew < 0) check("perf_args", 0, 1);
`endif
    endtask

    localparam logic [31:0] PAT = 32'hA5A5_5A5A;

    initial begin
        bit seen;
        rst = 1'b1; mem_read = 0; mem_write = 0; mem_address = '0;
        mem_wdata256 = '0; mem_byte_enable256 = '0; pmem_rdata256 = '0; pmem_resp = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mem_resp", mem_resp, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_addr", pmem_address, 0);
        rst = 1'b0;
        @(negedge clk);
        check_perf("rst_perf", 0, 0, 0);

        // ---- cold read, re-read, partial write, eviction of the dirty line ----
        mem[32'h100] = {8{PAT}};
        do_req(32'h100, 0, '0, '0);
        check("cold_rdata", last_rd, {8{PAT}});
        check("cold_miss", last_hit, 0);
        do_req(32'h100, 0, '0, '0);
        check("reread_hit", last_hit, 1);
        do_req(32'h100, 1, {{7{32'h1234_5678}}, 32'hDEAD_BEEF}, 32'h0000_000F);
        do_req(32'h100, 0, '0, '0);
        check("merged_rdata", last_rd, {{7{PAT}}, 32'hDEAD_BEEF});
        for (int a = 2; a <= 8; a++) do_req(32'h100 * a, 0, '0, '0);
        do_req(32'h900, 0, '0, '0);
        check("evict_wb", last_wb, 1);
        check("evict_wb_addr", last_wb_addr, 32'h100);
        check("evict_wb_data", last_wb_data, {{7{PAT}}, 32'hDEAD_BEEF});
        check_perf("scenA", 3, 9, 1);

        // ---- reset during a fill ----
        mem_address = 32'h40; mem_read = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        check("mid_rst_fill_seen", seen, 1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        check("mid_rst_pmem_read", pmem_read, 0);
        check("mid_rst_mem_resp", mem_resp, 0);
        check("mid_rst_pmem_write", pmem_write, 0);
        check("mid_rst_pmem_addr", pmem_address, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_perf("mid_rst_perf", 0, 0, 0);
        do_req(32'h900, 0, '0, '0);
        check("post_rst_miss", last_hit, 0);

        // ---- clean fill of set 0, PLRU victim, other set independent ----
        pulse_reset();
        for (int a = 1; a <= 8; a++) do_req(32'h100 * a, 0, '0, '0);
        do_req(32'h900, 0, '0, '0);
        check("clean_evict_no_wb", last_wb, 0);
        check("clean_evict_miss", last_hit, 0);
        do_req(32'h100, 0, '0, '0);
        check("way0_evicted", last_hit, 0);
        do_req(32'h20, 0, '0, '0);
        check("set1_miss", last_hit, 0);
        do_req(32'h800, 0, '0, '0);
        check("set0_unaffected", last_hit, 1);

        // ---- randomized traffic ----
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = {8'h0, 16'($urandom_range(0, 11)), 3'($urandom_range(0, 3)), 5'($urandom)};
            do_req(a, $urandom_range(0, 1) == 1, {8{$urandom}}, $urandom);
        end
        check_perf("final", m_hits, m_misses, m_wbs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
